axi_lite_avalon_bridge: RTL and testbench
=========================================

// Module: axi_lite_avalon_bridge
// PURPOSE
//  AXI4-Lite slave to Avalon-MM master bridge. Generalised, waitrequest-aware successor to the fixed AXI-Lite front end.
//  Write and read channels are captured independently and arbitrated onto one Avalon port.
//  Adds address-range decode, DECERR/SLVERR responses and a bus-timeout watchdog.
//  Sits between the AXI interconnect and the PCP/Avalon register slaves.
// PARAMETERS
//  C_BASEADDR          32'h0000_0000  first byte address decoded
//  C_HIGHADDR          32'h0000_FFFF  last byte address decoded (inclusive)
//  C_S_AXI_ADDR_WIDTH  32             AXI address width
//  C_S_AXI_DATA_WIDTH  32             AXI/Avalon data width; 32 or 64 only
//  C_AVM_ADDR_WIDTH    11             Avalon word-address width
//  C_TIMEOUT           256            waitrequest cycles before abort; 0 = no timeout
//  C_ARB_MODE          0              0 = round-robin write/read; 1 = read always wins
// PORTS
//  ACLK             in   1      clock; all logic on rising edge
//  ARESET           in   1      synchronous, active-high reset
//  S_AXI_AWADDR     in   AW     write address
//  S_AXI_AWPROT     in   3      ignored
//  S_AXI_AWVALID    in   1      write address valid
//  S_AXI_AWREADY    out  1      write address ready
//  S_AXI_WDATA      in   DW     write data
//  S_AXI_WSTRB      in   DW/8   write byte strobes
//  S_AXI_WVALID     in   1      write data valid
//  S_AXI_WREADY     out  1      write data ready
//  S_AXI_BRESP      out  2      00 OKAY, 10 SLVERR (timeout), 11 DECERR (out of range)
//  S_AXI_BVALID     out  1      write response valid
//  S_AXI_BREADY     in   1      write response ready
//  S_AXI_ARADDR     in   AW     read address
//  S_AXI_ARPROT     in   3      ignored
//  S_AXI_ARVALID    in   1      read address valid
//  S_AXI_ARREADY    out  1      read address ready
//  S_AXI_RDATA      out  DW     read data
//  S_AXI_RRESP      out  2      same encoding as BRESP
//  S_AXI_RVALID     out  1      read data valid
//  S_AXI_RREADY     in   1      read data ready
//  avm_address      out  C_AVM_ADDR_WIDTH  word address = (addr-C_BASEADDR)>>log2(DW/8)
//  avm_byteenable   out  DW/8   WSTRB on writes; all ones on reads
//  avm_read         out  1      read strobe
//  avm_write        out  1      write strobe
//  avm_writedata    out  DW     write data
//  avm_readdata     in   DW     sampled when avm_read=1 and avm_waitrequest=0
//  avm_waitrequest  in   1      slave stall
// BEHAVIOUR
//  Reset:
//   - All outputs 0 (READY/VALID/resp/RDATA/avm_*), FSM IDLE, holding flags clear, RR pointer = write.
//   - Reset mid-transfer aborts: strobes drop the cycle after ARESET is sampled; pending response discarded.
//  Capture:
//   - AWREADY = !aw_held, WREADY = !w_held, ARREADY = !ar_held (registered flags; low in reset).
//   - Each channel is captured on VALID&READY into its holding register; AW and W accepted in either order or same cycle.
//  FSM IDLE -> WR_ACC | RD_ACC | WR_RESP | RD_RESP; WR_ACC -> WR_RESP; RD_ACC -> RD_RESP; *_RESP -> IDLE.
//   - Write is ready when aw_held & w_held; read is ready when ar_held.
//   - Both ready: C_ARB_MODE 0 grants opposite of last grant; C_ARB_MODE 1 grants the read.
//   - Address outside [C_BASEADDR,C_HIGHADDR]: no Avalon cycle; go to *_RESP with resp 11, RDATA 0.
//   - In-range write with WSTRB=0: no Avalon cycle; WR_RESP with OKAY.
//  Avalon access (WR_ACC/RD_ACC):
//   - Strobe rises the cycle after the grant; address, byteenable and data are held stable while waitrequest=1.
//   - Completes the first cycle with waitrequest=0; RDATA <= avm_readdata; strobe drops next cycle.
//   - Watchdog counts waitrequest cycles. At C_TIMEOUT: drop strobe, resp 10, RDATA 0.
//  Response:
//   - BVALID/RVALID assert the cycle after completion; BRESP/RRESP/RDATA stay stable until the READY handshake.
//   - On handshake, the channel's holding flags clear (AWREADY/WREADY or ARREADY rise next cycle) and the FSM returns to IDLE.
//   - Zero-wait write latency: AW+W captured at edge N -> avm_write high N+1..N+2 -> BVALID at N+2.
//  Only one Avalon transaction is outstanding at a time; the new channel may be captured while the other is in flight.
// TESTING
//  - Write 0x10=0xCAFEF00D, WSTRB=F, waitreq 0 -> avm_write 1 cycle, address 0x4, BVALID 2 cycles after capture, BRESP 00.
//  - W one cycle before AW, waitreq high 3 cycles -> write held 4 cycles, data stable; BRESP 00.
//  - Read 0x20000 with HIGHADDR=0xFFFF -> no avm_read; RVALID, RRESP 11, RDATA 0.
//  - Read with waitreq stuck high, C_TIMEOUT=8 -> avm_read dropped after 8 cycles; RRESP 10.
//  - AW/W/AR all valid same cycle, C_ARB_MODE 0 -> write first, then read; repeat -> read first.
//  - ARESET mid-WR_ACC -> avm_write 0 next cycle, BVALID never set, all READYs low while reset held.

Source files
------------

// File: rtl/axi_lite_avalon_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_avalon_bridge
// Brief    : AXI4-Lite slave to Avalon-MM master with decode, error responses
//            and waitrequest watchdog.
// Revision : 1.0
// ============================================================================
module axi_lite_avalon_bridge #(
    parameter int                              C_S_AXI_ADDR_WIDTH = 32,
    parameter int                              C_S_AXI_DATA_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0]   C_BASEADDR         = 32'h0000_0000,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0]   C_HIGHADDR         = 32'h0000_FFFF,
    parameter int                              C_AVM_ADDR_WIDTH   = 11,
    parameter int                              C_TIMEOUT          = 256,
    parameter int                              C_ARB_MODE         = 0
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic [2:0]                          S_AXI_AWPROT,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,
    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic [2:0]                          S_AXI_ARPROT,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    output logic [C_AVM_ADDR_WIDTH-1:0]         avm_address,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]     avm_byteenable,
    output logic                                avm_read,
    output logic                                avm_write,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       avm_writedata,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       avm_readdata,
    input  logic                                avm_waitrequest
);

    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int SW       = DW / 8;
    localparam int ADDR_LSB = $clog2(SW);
    localparam int TW       = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((C_TIMEOUT > 0) ? (C_TIMEOUT - 1) : 0);
    localparam logic [AW-1:0] SPAN    = C_HIGHADDR - C_BASEADDR;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ACC  = 3'd1,
        S_RD_ACC  = 3'd2,
        S_WR_RESP = 3'd3,
        S_RD_RESP = 3'd4
    } state_t;

    state_t             state_q;
    logic               aw_held_q, aw_held_d;
    logic               w_held_q,  w_held_d;
    logic               ar_held_q, ar_held_d;
    logic               awready_q, wready_q, arready_q;
    logic [AW-1:0]      awaddr_q, araddr_q;
    logic [DW-1:0]      wdata_q;
    logic [SW-1:0]      wstrb_q;

    logic               bvalid_q, rvalid_q;
    logic [1:0]         bresp_q, rresp_q;
    logic [DW-1:0]      rdata_q;
    logic [C_AVM_ADDR_WIDTH-1:0] avm_address_q;
    logic [SW-1:0]      avm_byteenable_q;
    logic [DW-1:0]      avm_writedata_q;
    logic               avm_read_q, avm_write_q;
    logic               rr_rd_q;
    logic [TW-1:0]      wd_cnt_q;

    logic               w_b_done, w_r_done;
    logic               w_wr_rdy, w_rd_rdy, w_contend;
    logic               w_grant_wr, w_grant_rd;
    logic [AW-1:0]      w_wr_off, w_rd_off;
    logic               w_wr_in_range, w_rd_in_range;
    logic               w_timeout;
    logic               w_unused;

    assign w_b_done = bvalid_q & S_AXI_BREADY;
    assign w_r_done = rvalid_q & S_AXI_RREADY;

    // ------------------------------------------------------------------
    // Channel capture: each channel owns a one-deep holding register
    // ------------------------------------------------------------------
    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        ar_held_d = ar_held_q;
        if (S_AXI_AWVALID && awready_q) aw_held_d = 1'b1;
        if (S_AXI_WVALID  && wready_q)  w_held_d  = 1'b1;
        if (S_AXI_ARVALID && arready_q) ar_held_d = 1'b1;
        if (w_b_done) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        if (w_r_done) ar_held_d = 1'b0;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            ar_held_q <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            ar_held_q <= ar_held_d;
            awready_q <= !aw_held_d;
            wready_q  <= !w_held_d;
            arready_q <= !ar_held_d;
            if (S_AXI_AWVALID && awready_q) awaddr_q <= S_AXI_AWADDR;
            if (S_AXI_ARVALID && arready_q) araddr_q <= S_AXI_ARADDR;
            if (S_AXI_WVALID && wready_q) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
        end
    end

    // Offsets wrap on addresses below the base, so one compare covers both ends.
    assign w_wr_off      = awaddr_q - C_BASEADDR;
    assign w_rd_off      = araddr_q - C_BASEADDR;
    assign w_wr_in_range = (w_wr_off <= SPAN);
    assign w_rd_in_range = (w_rd_off <= SPAN);

    assign w_wr_rdy  = aw_held_q & w_held_q;
    assign w_rd_rdy  = ar_held_q;
    assign w_contend = w_wr_rdy & w_rd_rdy;

    // The round-robin pointer only moves on contested grants.
    always_comb begin
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        if (w_contend) begin
            if ((C_ARB_MODE == 1) || rr_rd_q) w_grant_rd = 1'b1;
            else                              w_grant_wr = 1'b1;
        end else if (w_wr_rdy) begin
            w_grant_wr = 1'b1;
        end else if (w_rd_rdy) begin
            w_grant_rd = 1'b1;
        end
    end

    assign w_timeout = (C_TIMEOUT != 0) && (wd_cnt_q == TO_LAST);

    // ------------------------------------------------------------------
    // Transfer FSM with registered Avalon and response outputs
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q          <= S_IDLE;
            avm_address_q    <= '0;
            avm_byteenable_q <= '0;
            avm_writedata_q  <= '0;
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            bvalid_q         <= 1'b0;
            rvalid_q         <= 1'b0;
            bresp_q          <= RESP_OKAY;
            rresp_q          <= RESP_OKAY;
            rdata_q          <= '0;
            rr_rd_q          <= 1'b0;
            wd_cnt_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wd_cnt_q <= '0;
                    if (w_contend) rr_rd_q <= w_grant_wr;
                    if (w_grant_wr) begin
                        if (!w_wr_in_range) begin
                            bresp_q  <= RESP_DECERR;
                            bvalid_q <= 1'b1;
                            state_q  <= S_WR_RESP;
                        end else if (wstrb_q == '0) begin
                            bresp_q  <= RESP_OKAY;
                            bvalid_q <= 1'b1;
                            state_q  <= S_WR_RESP;
                        end else begin
                            avm_address_q    <= w_wr_off[ADDR_LSB +: C_AVM_ADDR_WIDTH];
                            avm_byteenable_q <= wstrb_q;
                            avm_writedata_q  <= wdata_q;
                            avm_write_q      <= 1'b1;
                            state_q          <= S_WR_ACC;
                        end
                    end else if (w_grant_rd) begin
                        if (!w_rd_in_range) begin
                            rresp_q  <= RESP_DECERR;
                            rdata_q  <= '0;
                            rvalid_q <= 1'b1;
                            state_q  <= S_RD_RESP;
                        end else begin
                            avm_address_q    <= w_rd_off[ADDR_LSB +: C_AVM_ADDR_WIDTH];
                            avm_byteenable_q <= {SW{1'b1}};
                            avm_read_q       <= 1'b1;
                            state_q          <= S_RD_ACC;
                        end
                    end
                end

                S_WR_ACC: begin
                    if (!avm_waitrequest) begin
                        avm_write_q <= 1'b0;
                        bresp_q     <= RESP_OKAY;
                        bvalid_q    <= 1'b1;
                        state_q     <= S_WR_RESP;
                    end else if (w_timeout) begin
                        avm_write_q <= 1'b0;
                        bresp_q     <= RESP_SLVERR;
                        bvalid_q    <= 1'b1;
                        state_q     <= S_WR_RESP;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end

                S_RD_ACC: begin
                    if (!avm_waitrequest) begin
                        avm_read_q <= 1'b0;
                        rresp_q    <= RESP_OKAY;
                        rdata_q    <= avm_readdata;
                        rvalid_q   <= 1'b1;
                        state_q    <= S_RD_RESP;
                    end else if (w_timeout) begin
                        avm_read_q <= 1'b0;
                        rresp_q    <= RESP_SLVERR;
                        rdata_q    <= '0;
                        rvalid_q   <= 1'b1;
                        state_q    <= S_RD_RESP;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end

                S_WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end

                S_RD_RESP: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY  = awready_q;
    assign S_AXI_WREADY   = wready_q;
    assign S_AXI_ARREADY  = arready_q;
    assign S_AXI_BVALID   = bvalid_q;
    assign S_AXI_BRESP    = bresp_q;
    assign S_AXI_RVALID   = rvalid_q;
    assign S_AXI_RRESP    = rresp_q;
    assign S_AXI_RDATA    = rdata_q;
    assign avm_address    = avm_address_q;
    assign avm_byteenable = avm_byteenable_q;
    assign avm_writedata  = avm_writedata_q;
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;

    // Protection attributes carry no meaning for the register slaves.
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_avalon_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_avalon_bridge
// Brief    : Directed table-driven bench for axi_lite_avalon_bridge.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_axi_lite_avalon_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int MAW = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0]  awaddr = '0, araddr = '0;
    logic           awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic           bready = 1'b1, rready = 1'b1;
    logic [DW-1:0]  wdata = '0;
    logic [SW-1:0]  wstrb = '0;
    logic           awready, wready, arready, bvalid, rvalid;
    logic [1:0]     bresp, rresp;
    logic [DW-1:0]  rdata;
    logic [MAW-1:0] avm_address;
    logic [SW-1:0]  avm_be;
    logic           avm_read, avm_write;
    logic [DW-1:0]  avm_wdata;
    logic [DW-1:0]  avm_rdata = '0;
    logic           avm_wait = 1'b0;

    axi_lite_avalon_bridge #(
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_S_AXI_DATA_WIDTH (DW),
        .C_BASEADDR         (32'h0000_0000),
        .C_HIGHADDR         (32'h0000_FFFF),
        .C_AVM_ADDR_WIDTH   (MAW),
        .C_TIMEOUT          (8),
        .C_ARB_MODE         (0)
    ) dut (
        .ACLK            (clk),
        .ARESET          (rst),
        .S_AXI_AWADDR    (awaddr),
        .S_AXI_AWPROT    (3'b000),
        .S_AXI_AWVALID   (awvalid),
        .S_AXI_AWREADY   (awready),
        .S_AXI_WDATA     (wdata),
        .S_AXI_WSTRB     (wstrb),
        .S_AXI_WVALID    (wvalid),
        .S_AXI_WREADY    (wready),
        .S_AXI_BRESP     (bresp),
        .S_AXI_BVALID    (bvalid),
        .S_AXI_BREADY    (bready),
        .S_AXI_ARADDR    (araddr),
        .S_AXI_ARPROT    (3'b000),
        .S_AXI_ARVALID   (arvalid),
        .S_AXI_ARREADY   (arready),
        .S_AXI_RDATA     (rdata),
        .S_AXI_RRESP     (rresp),
        .S_AXI_RVALID    (rvalid),
        .S_AXI_RREADY    (rready),
        .avm_address     (avm_address),
        .avm_byteenable  (avm_be),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_wdata),
        .avm_readdata    (avm_rdata),
        .avm_waitrequest (avm_wait)
    );

    // Avalon slave: stalls wait_n cycles per strobe episode and records what it saw.
    int             wait_n = 0;
    int             wcnt = 0;
    bit             strb_prev = 1'b0;
    int             strb_cycles = 0;
    int             n_access = 0;
    logic [MAW-1:0] mon_addr = '0;
    logic [DW-1:0]  mon_wdata = '0;
    logic [SW-1:0]  mon_be = '0;
    bit             mon_unstable = 1'b0;
    bit             kinds[$];

    always @(negedge clk) begin
        if (avm_read || avm_write) begin
            if (!strb_prev) begin
                strb_cycles  = 1;
                mon_addr     = avm_address;
                mon_wdata    = avm_wdata;
                mon_be       = avm_be;
                mon_unstable = 1'b0;
                n_access     = n_access + 1;
                kinds.push_back(avm_write);
            end else begin
                strb_cycles = strb_cycles + 1;
                if (avm_address !== mon_addr || avm_wdata !== mon_wdata || avm_be !== mon_be)
                    mon_unstable = 1'b1;
            end
            if (wcnt < wait_n) begin
                avm_wait = 1'b1;
                wcnt     = wcnt + 1;
            end else begin
                avm_wait = 1'b0;
            end
        end else begin
            avm_wait = 1'b0;
            wcnt     = 0;
        end
        strb_prev = avm_read || avm_write;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Both tasks start and end on a falling edge; lat counts rising edges from capture to VALID.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output bit ok, output logic [1:0] resp, output int lat);
        bit aw_go, w_go;
        aw_go = 1'b0; w_go = 1'b0; ok = 1'b0; lat = 0; resp = 2'b00;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        for (int t = 0; t < 20 && !(aw_go && w_go); t++) begin
            if (awvalid && awready) aw_go = 1'b1;
            if (wvalid && wready)   w_go  = 1'b1;
            @(negedge clk);
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (aw_go && w_go) begin
            for (int t = 0; t < 40; t++) begin
                if (bvalid) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
                lat = lat + 1;
            end
            resp = bresp;
            @(negedge clk);
        end
    endtask

    task automatic do_read(input logic [31:0] a, output bit ok, output logic [1:0] resp,
                           output logic [31:0] data, output int lat);
        bit go;
        go = 1'b0; ok = 1'b0; lat = 0; resp = 2'b00; data = '0;
        araddr = a; arvalid = 1'b1;
        for (int t = 0; t < 20 && !go; t++) begin
            if (arready) go = 1'b1;
            @(negedge clk);
        end
        arvalid = 1'b0;
        if (go) begin
            for (int t = 0; t < 40; t++) begin
                if (rvalid) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
                lat = lat + 1;
            end
            resp = rresp;
            data = rdata;
            @(negedge clk);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] slv_rdata;
        logic [1:0]  eresp;
        logic [31:0] erdata;
        int          elat;
        bit          eacc;
        logic [10:0] eaddr;
        logic [3:0]  ebe;
        int          ecyc;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation stuck expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t        v;
        bit          ok, got, nb, nr, seen_b;
        logic [1:0]  resp;
        logic [31:0] rd;
        int          lat, acc0;

        //        wr  addr          wdata         strb   wt    slave rdata   resp   rdata         lat acc eaddr    be     cyc
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 0,    32'h0,        2'b00, 32'h0,        2, 1'b1, 11'h004, 4'hF, 1};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 0,    32'h1234_5678, 2'b00, 32'h1234_5678, 2, 1'b1, 11'h004, 4'hF, 1};
        vecs[2] = '{1'b1, 32'h0000_FFFC, 32'hA5A5_0001, 4'h3, 2,    32'h0,        2'b00, 32'h0,        4, 1'b1, 11'h7FF, 4'h3, 3};
        vecs[3] = '{1'b0, 32'h0000_FFFC, 32'h0,        4'h0, 1,    32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 3, 1'b1, 11'h7FF, 4'hF, 2};
        vecs[4] = '{1'b0, 32'h0002_0000, 32'h0,        4'h0, 0,    32'h55AA_55AA, 2'b11, 32'h0,        1, 1'b0, 11'h000, 4'h0, 0};
        vecs[5] = '{1'b1, 32'h0001_0000, 32'h0000_1234, 4'hF, 0,    32'h0,        2'b11, 32'h0,        1, 1'b0, 11'h000, 4'h0, 0};
        vecs[6] = '{1'b1, 32'h0000_0040, 32'h0000_9999, 4'h0, 0,    32'h0,        2'b00, 32'h0,        1, 1'b0, 11'h000, 4'h0, 0};
        vecs[7] = '{1'b0, 32'h0000_0008, 32'h0,        4'h0, 1000, 32'hFFFF_FFFF, 2'b10, 32'h0,        9, 1'b1, 11'h002, 4'hF, 8};
        vecs[8] = '{1'b1, 32'h0000_0024, 32'h0F0F_0F0F, 4'h8, 1000, 32'h0,        2'b10, 32'h0,        9, 1'b1, 11'h009, 4'h8, 8};
        vecs[9] = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 0,    32'h0BAD_CAFE, 2'b00, 32'h0BAD_CAFE, 2, 1'b1, 11'h000, 4'hF, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst readies", {awready, wready, arready}, 3'b000);
        check("rst valids", {bvalid, rvalid}, 2'b00);
        check("rst strobes", {avm_read, avm_write}, 2'b00);
        check("rst rdata", rdata, 32'h0);
        check("rst resps", {bresp, rresp}, 4'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst readies", {awready, wready, arready}, 3'b111);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            wait_n = v.waits;
            avm_rdata = v.slv_rdata;
            acc0 = n_access;
            rd = '0;
            if (v.wr) do_write(v.addr, v.wdata, v.strb, ok, resp, lat);
            else      do_read(v.addr, ok, resp, rd, lat);
            check($sformatf("v%0d completed", i), ok, 1);
            check($sformatf("v%0d resp", i), resp, v.eresp);
            check($sformatf("v%0d latency", i), lat, v.elat);
            check($sformatf("v%0d avalon access", i), n_access - acc0, v.eacc);
            if (!v.wr) check($sformatf("v%0d rdata", i), rd, v.erdata);
            if (v.eacc) begin
                check($sformatf("v%0d avm_address", i), mon_addr, v.eaddr);
                check($sformatf("v%0d byteenable", i), mon_be, v.ebe);
                check($sformatf("v%0d strobe cycles", i), strb_cycles, v.ecyc);
                check($sformatf("v%0d stable", i), mon_unstable, 0);
                if (v.wr) check($sformatf("v%0d writedata", i), mon_wdata, v.wdata);
            end
        end

        // W leads AW by a cycle, three stall cycles, response held off by BREADY
        wait_n = 3; bready = 1'b0; acc0 = n_access;
        wdata = 32'h600D_F00D; wstrb = 4'hF; wvalid = 1'b1;
        check("A wready idle", wready, 1);
        @(negedge clk);
        wvalid = 1'b0; awaddr = 32'h0000_0100; awvalid = 1'b1;
        check("A wready held", wready, 0);
        @(negedge clk);
        awvalid = 1'b0;
        check("A awready held", awready, 0);
        got = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (bvalid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("A bvalid seen", got, 1);
        repeat (3) begin
            check("A bvalid hold", bvalid, 1);
            check("A bresp hold", bresp, 2'b00);
            check("A awready low", awready, 0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        check("A bvalid cleared", bvalid, 0);
        check("A readies back", {awready, wready}, 2'b11);
        check("A strobe cycles", strb_cycles, 4);
        check("A stable", mon_unstable, 0);
        check("A address", mon_addr, 11'h040);
        check("A writedata", mon_wdata, 32'h600D_F00D);
        check("A one access", n_access - acc0, 1);

        // Simultaneous AW/W/AR twice: round-robin flips the winner
        wait_n = 0;
        for (int r = 0; r < 2; r++) begin
            kinds.delete();
            avm_rdata = 32'h0000_A0A0 + r;
            awaddr = 32'h30; wdata = 32'h1111_1111 * (r + 1); wstrb = 4'hF;
            araddr = 32'h34;
            check($sformatf("C%0d readies", r), {awready, wready, arready}, 3'b111);
            awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
            @(negedge clk);
            awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
            nb = 1'b0; nr = 1'b0; rd = '0; resp = 2'b11;
            for (int t = 0; t < 40 && !(nb && nr); t++) begin
                if (bvalid) begin
                    nb = 1'b1;
                    resp = bresp;
                end
                if (rvalid) begin
                    nr = 1'b1;
                    rd = rdata;
                end
                @(negedge clk);
            end
            check($sformatf("C%0d both responses", r), {nb, nr}, 2'b11);
            check($sformatf("C%0d bresp", r), resp, 2'b00);
            check($sformatf("C%0d rdata", r), rd, 32'h0000_A0A0 + r);
            check($sformatf("C%0d access count", r), kinds.size(), 2);
            check($sformatf("C%0d first is write", r), kinds[0], (r == 0) ? 1 : 0);
            check($sformatf("C%0d second is write", r), kinds[1], (r == 0) ? 0 : 1);
        end

        // Reset while the write is stalled on the Avalon side
        wait_n = 1000;
        awaddr = 32'h50; wdata = 32'h7777_7777; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (avm_write) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("D write started", got, 1);
        rst = 1'b1;
        @(negedge clk);
        check("D avm_write dropped", avm_write, 0);
        repeat (3) begin
            check("D readies low", {awready, wready, arready}, 3'b000);
            check("D bvalid low", bvalid, 0);
            @(negedge clk);
        end
        rst = 1'b0; wait_n = 0;
        seen_b = 1'b0;
        repeat (6) begin
            if (bvalid) seen_b = 1'b1;
            @(negedge clk);
        end
        check("D no stale bvalid", seen_b, 0);
        check("D readies after reset", {awready, wready, arready}, 3'b111);
        do_write(32'h0000_0010, 32'h0000_0042, 4'hF, ok, resp, lat);
        check("D recovery write", {ok, resp}, 3'b100);
        check("D recovery latency", lat, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
